// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD responder: bus encodings,
// instruction opcodes and the controller state enumeration.
package lcd_pkg;

    // lcd_ctrl = {RS, RW}
    localparam logic [1:0] CtrlInstrWr  = 2'b00;
    localparam logic [1:0] CtrlStatusRd = 2'b01;
    localparam logic [1:0] CtrlDataWr   = 2'b10;
    localparam logic [1:0] CtrlDataRd   = 2'b11;

    // Instruction opcodes, matched as (byte & mask) == value
    localparam logic [7:0] OpClear     = 8'h01;
    localparam logic [7:0] OpHomeMask  = 8'hFE;
    localparam logic [7:0] OpHome      = 8'h02;
    localparam logic [7:0] OpEntryMask = 8'hFC;
    localparam logic [7:0] OpEntry     = 8'h04;
    localparam logic [7:0] OpSetAddr   = 8'h80;

    // Character written to every cell by a clear
    localparam logic [7:0] ClearFill = 8'h20;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StExec
    } lcd_state_e;

    // Step an address one place in the entry direction, wrapping at both ends
    function automatic logic [6:0] step_addr(input logic [6:0] cur, input logic inc,
                                             input logic [6:0] last);
        if (inc) begin
            return (cur == last) ? 7'd0 : cur + 7'd1;
        end
        return (cur == 7'd0) ? last : cur - 7'd1;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// Display data RAM: one synchronous write port, an asynchronous read port
// for the cursor and a registered read port for the display scanner.
module lcd_ddram #(
    parameter int unsigned DEPTH = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [6:0] waddr,
    input  logic [7:0] wdata,
    input  logic [6:0] raddr,
    output logic [7:0] rdata,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char
);
    localparam logic [7:0] DepthW = 8'(DEPTH);

    // Contents are deliberately not reset; a clear instruction initialises them.
    logic [7:0] mem [DEPTH];

    // Write port; out-of-range addresses are dropped
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < DepthW)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < DepthW) ? mem[raddr] : 8'h00;

    // Registered scan port, one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_char <= 8'h00;
        end else begin
            disp_char <= ({1'b0, disp_addr} < DepthW) ? mem[disp_addr] : 8'h00;
        end
    end

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD bus responder: executes instructions and data accesses on the
// falling edge of a synchronised enable strobe and models the busy period.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned DEPTH        = 80,
    parameter int unsigned BUSY_CYCLES  = 37,
    parameter int unsigned CLEAR_CYCLES = 152
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    output logic [7:0] lcd_rdata,
    output logic       busy,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [6:0] cursor,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       err
);
    localparam logic [6:0]  LastAddr  = 7'(DEPTH - 1);
    localparam logic [7:0]  DepthW    = 8'(DEPTH);
    // EXEC holds busy for exactly the loaded count + 1 cycles
    localparam logic [15:0] BusyLoad  = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] ClearLoad = 16'(CLEAR_CYCLES - 1);

    lcd_state_e  state_q;
    logic [15:0] cnt_q;
    logic [6:0]  clr_addr_q;
    logic [6:0]  cursor_q;
    logic        inc_q;
    logic [1:0]  sync_q;
    logic        en_prev_q;
    logic        char_valid_q;
    logic [7:0]  char_data_q;
    logic [7:0]  rdata_q;
    logic        err_q;

    logic        fall;
    logic        is_status;
    logic        can_accept;
    logic        take;
    logic        reject;
    logic [6:0]  cursor_step;
    logic        ram_we;
    logic [6:0]  ram_waddr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    // Enable synchroniser plus the flop used for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            en_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], lcd_enable};
            en_prev_q <= sync_q[1];
        end
    end

    // Event qualification and RAM write-port steering
    always_comb begin
        fall      = en_prev_q & ~sync_q[1];
        is_status = (lcd_ctrl == CtrlStatusRd);
        // The last EXEC cycle (count at zero) may already accept new work
        can_accept  = (state_q == StIdle) || ((state_q == StExec) && (cnt_q == '0));
        take        = fall && can_accept && !is_status;
        reject      = fall && !can_accept && !is_status;
        cursor_step = step_addr(cursor_q, inc_q, LastAddr);
        ram_we      = (state_q == StClear) || (take && (lcd_ctrl == CtrlDataWr));
        ram_waddr   = (state_q == StClear) ? clr_addr_q : cursor_q;
        ram_wdata   = (state_q == StClear) ? ClearFill : lcd_data;
    end

    // Controller FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            clr_addr_q   <= '0;
            cursor_q     <= '0;
            inc_q        <= 1'b1;
            char_valid_q <= 1'b0;
            char_data_q  <= 8'h00;
            rdata_q      <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            char_valid_q <= 1'b0;

            unique case (state_q)
                StClear: begin
                    if (clr_addr_q == LastAddr) begin
                        state_q <= StExec;
                        cnt_q   <= ClearLoad;
                    end else begin
                        clr_addr_q <= clr_addr_q + 7'd1;
                    end
                end
                StExec: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                default: ;
            endcase

            // An accepted transaction overrides the default progression above
            if (take) begin
                state_q <= StExec;
                cnt_q   <= BusyLoad;
                unique case (lcd_ctrl)
                    CtrlDataWr: begin
                        char_valid_q <= 1'b1;
                        char_data_q  <= lcd_data;
                        cursor_q     <= cursor_step;
                    end
                    CtrlDataRd: begin
                        cursor_q <= cursor_step;
                    end
                    CtrlInstrWr: begin
                        if (lcd_data == OpClear) begin
                            state_q    <= StClear;
                            clr_addr_q <= '0;
                            cursor_q   <= '0;
                            inc_q      <= 1'b1;
                        end else if ((lcd_data & OpHomeMask) == OpHome) begin
                            cursor_q <= '0;
                        end else if ((lcd_data & OpEntryMask) == OpEntry) begin
                            inc_q <= lcd_data[1];
                        end else if ((lcd_data & OpSetAddr) != 8'h00) begin
                            cursor_q <= ({1'b0, lcd_data[6:0]} < DepthW) ? lcd_data[6:0] : 7'd0;
                        end
                    end
                    default: ;
                endcase
            end

            if (reject) begin
                err_q <= 1'b1;
            end

            unique case (lcd_ctrl)
                CtrlStatusRd: rdata_q <= {busy, cursor_q};
                CtrlDataRd:   rdata_q <= ram_rdata;
                default:      rdata_q <= 8'h00;
            endcase
        end
    end

    lcd_ddram #(
        .DEPTH(DEPTH)
    ) u_ddram (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .raddr    (cursor_q),
        .rdata    (ram_rdata),
        .disp_addr(disp_addr),
        .disp_char(disp_char)
    );

    assign busy       = (state_q != StIdle);
    assign char_valid = char_valid_q;
    assign char_data  = char_data_q;
    assign cursor     = cursor_q;
    assign lcd_rdata  = rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Self-checking bench for lcd_responder: directed scenarios followed by a
// random transaction stream checked against a behavioural display model.
module tb_lcd_responder;
    localparam int DEPTH        = 80;
    localparam int BUSY_CYCLES  = 37;
    localparam int CLEAR_CYCLES = 152;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
    logic [7:0] lcd_rdata;
    logic       busy;
    logic       char_valid;
    logic [7:0] char_data;
    logic [6:0] cursor;
    logic [6:0] disp_addr;
    logic [7:0] disp_char;
    logic       err;

    lcd_responder #(
        .DEPTH       (DEPTH),
        .BUSY_CYCLES (BUSY_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lcd_data  (lcd_data),
        .lcd_ctrl  (lcd_ctrl),
        .lcd_enable(lcd_enable),
        .lcd_rdata (lcd_rdata),
        .busy      (busy),
        .char_valid(char_valid),
        .char_data (char_data),
        .cursor    (cursor),
        .disp_addr (disp_addr),
        .disp_char (disp_char),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Display model
    logic [7:0] mem_m [DEPTH];
    int         cur_m = 0;
    bit         inc_m = 1'b1;
    bit         err_m = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int step_m(input int c, input bit inc);
        return inc ? (c + 1) % DEPTH : (c + DEPTH - 1) % DEPTH;
    endfunction

    // Apply one accepted transaction to the model
    task automatic model_apply(input logic [1:0] c, input logic [7:0] d, output int exp_busy,
                               output bit exp_cv, output logic [7:0] exp_rd);
        int a;
        exp_busy = BUSY_CYCLES;
        exp_cv   = 1'b0;
        exp_rd   = 8'h00;
        case (c)
            2'b10: begin
                mem_m[cur_m] = d;
                exp_cv       = 1'b1;
                cur_m        = step_m(cur_m, inc_m);
            end
            2'b11: begin
                exp_rd = mem_m[cur_m];
                cur_m  = step_m(cur_m, inc_m);
            end
            2'b00: begin
                if (d == 8'h01) begin
                    foreach (mem_m[i]) mem_m[i] = 8'h20;
                    cur_m    = 0;
                    inc_m    = 1'b1;
                    exp_busy = DEPTH + CLEAR_CYCLES;
                end else if (d == 8'h02 || d == 8'h03) begin
                    cur_m = 0;
                end else if (d >= 8'h04 && d <= 8'h07) begin
                    inc_m = d[1];
                end else if (d >= 8'h80) begin
                    a     = int'(d) - 128;
                    cur_m = (a < DEPTH) ? a : 0;
                end
            end
            default: ;
        endcase
    endtask

    // Enable pulse; returns on the sample point just after the action edge
    task automatic pulse(input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        lcd_ctrl   = c;
        lcd_data   = d;
        lcd_enable = 1'b1;
        repeat (2) @(negedge clk);
        lcd_enable = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_xact(input logic [1:0] c, input logic [7:0] d);
        int         eb;
        int         n;
        bit         ecv;
        logic [7:0] erd;
        model_apply(c, d, eb, ecv, erd);
        pulse(c, d);
        chk("char_valid", char_valid, ecv);
        if (ecv) chk("char_data", char_data, d);
        if (c == 2'b11) chk("rdata_ddram", lcd_rdata, erd);
        chk("busy_start", busy, 1);
        @(negedge clk);
        chk("char_valid_width", char_valid, 0);
        wait_idle(n);
        chk("busy_len", n, eb - 1);
        chk("cursor", cursor, cur_m);
        chk("err", err, err_m);
    endtask

    task automatic disp_chk(input int a, input string tag);
        @(negedge clk);
        disp_addr = 7'(a);
        @(negedge clk);
        chk($sformatf("%s[%0d]", tag, a), disp_char, mem_m[a]);
    endtask

    task automatic scan(input string tag);
        for (int a = 0; a < DEPTH; a++) disp_chk(a, tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        int         eb;
        bit         ecv;
        logic [7:0] erd;
        logic [7:0] d;
        int         k;

        rst_n      = 1'b0;
        lcd_enable = 1'b0;
        lcd_ctrl   = 2'b01;
        lcd_data   = 8'h00;
        disp_addr  = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_cursor", cursor, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_data", char_data, 8'h00);
        chk("rst_rdata", lcd_rdata, 8'h00);
        chk("rst_disp_char", disp_char, 8'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", busy, 0);

        // Clear fills the display and holds busy for DEPTH + CLEAR_CYCLES
        do_xact(2'b00, 8'h01);
        chk("clear_cursor", cursor, 0);
        scan("clear_fill");

        // "Hi"
        do_xact(2'b10, 8'h48);
        do_xact(2'b10, 8'h69);
        chk("hi_cursor", cursor, 2);
        disp_chk(0, "hi");
        disp_chk(1, "hi");

        // Last address then increment wraps
        do_xact(2'b00, 8'h80 | 8'd79);
        do_xact(2'b10, 8'h41);
        chk("wrap_inc_cursor", cursor, 0);
        disp_chk(79, "wrap_inc");

        // Decrement from 0 wraps
        do_xact(2'b00, 8'h04);
        do_xact(2'b10, 8'h42);
        chk("wrap_dec_cursor", cursor, 79);
        disp_chk(0, "wrap_dec");

        // Status reads while busy and after
        model_apply(2'b00, 8'h83, eb, ecv, erd);
        pulse(2'b00, 8'h83);
        lcd_ctrl = 2'b01;
        @(negedge clk);
        chk("status_busy", lcd_rdata, 8'h83);
        pulse(2'b01, 8'h00);
        chk("status_pulse_busy", lcd_rdata, 8'h83);
        chk("status_no_err", err, 0);
        wait_idle(n);
        chk("status_no_restart", n, BUSY_CYCLES - 7);
        @(negedge clk);
        chk("status_idle", lcd_rdata, 8'h03);

        // Transaction detected on the final busy cycle is accepted
        model_apply(2'b00, 8'h10, eb, ecv, erd);
        pulse(2'b00, 8'h10);
        repeat (BUSY_CYCLES - 6) @(negedge clk);
        do_xact(2'b10, 8'h55);

        // Second strobe during busy is ignored and flags err
        model_apply(2'b10, 8'h61, eb, ecv, erd);
        pulse(2'b10, 8'h61);
        chk("first_write_valid", char_valid, 1);
        pulse(2'b10, 8'h62);
        err_m = 1'b1;
        chk("overrun_err", err, 1);
        chk("overrun_no_char", char_valid, 0);
        wait_idle(n);
        chk("overrun_cursor", cursor, cur_m);
        scan("overrun");

        // Random transaction stream
        for (int i = 0; i < 60; i++) begin
            k = int'($urandom_range(0, 5));
            case (k)
                0, 1: begin
                    d = 8'($urandom_range(8'h21, 8'h7E));
                    do_xact(2'b10, d);
                end
                2: do_xact(2'b11, 8'h00);
                3: begin
                    d = 8'(8'h80 | $urandom_range(0, 127));
                    do_xact(2'b00, d);
                end
                4: begin
                    d = 8'(8'h04 | $urandom_range(0, 3));
                    do_xact(2'b00, d);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) d = 8'($urandom_range(2, 3));
                    else d = 8'($urandom_range(8'h08, 8'h7F));
                    do_xact(2'b00, d);
                end
            endcase
        end
        scan("random");

        // Reset during the clear fill stops it after the cells already written
        pulse(2'b00, 8'h01);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) mem_m[i] = 8'h20;
        cur_m = 0;
        inc_m = 1'b1;
        err_m = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_cursor", cursor, 0);
        chk("abort_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_stays_idle", busy, 0);
        scan("abort");
        do_xact(2'b10, 8'h5A);
        chk("abort_dir_inc", cursor, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
